id_ex_reg: RTL

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/pipeline_pkg.sv | 45 ++++
 rtl/id_ex_reg_if.sv | 65 ++++++
 rtl/alu_ctrl_dec.sv | 32 +++
 rtl/id_ex_reg.sv | 74 +++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: ALU codes, decoder classes and the ID/EX bundle.
// Used by the ID/EX register, the ALU and the EX/MEM register.
package pipeline_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_ILL = 4'b1111;

    localparam logic [1:0] AOP_MEM = 2'b00;
    localparam logic [1:0] AOP_BR  = 2'b01;
    localparam logic [1:0] AOP_R   = 2'b10;
    localparam logic [1:0] AOP_I   = 2'b11;

    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic       alu_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic [3:0] alu_control;
    } id_ex_ctrl_t;

    typedef struct packed {
        id_ex_ctrl_t ctrl;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
    } id_ex_t;

    function automatic id_ex_t bubble();
        id_ex_t b;
        b = '0;
        b.ctrl.alu_control = ALU_ADD;
        return b;
    endfunction

endpackage

// File: rtl/id_ex_reg_if.sv
// ID/EX boundary bundle: ID-side inputs, hazard controls, EX-side outputs.
interface id_ex_reg_if;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;

    logic [31:0] out_rs1_data;
    logic [31:0] out_rs2_data;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1_addr;
    logic [4:0]  out_rs2_addr;
    logic [4:0]  out_rd_addr;
    logic        out_alu_src;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_mem_to_reg;
    logic        out_branch;
    logic [3:0]  alu_control;
    logic        out_valid;
    logic        illegal_op;

    modport master (
        output stall, flush, in_valid,
        output rs1_data, rs2_data, imm,
        output rs1_addr, rs2_addr, rd_addr,
        output alu_op, funct3, funct7_b5,
        output alu_src, reg_write, mem_read,
        output mem_write, mem_to_reg, branch,
        input  out_rs1_data, out_rs2_data, out_imm,
        input  out_rs1_addr, out_rs2_addr, out_rd_addr,
        input  out_alu_src, out_reg_write, out_mem_read,
        input  out_mem_write, out_mem_to_reg, out_branch,
        input  alu_control, out_valid, illegal_op
    );

    modport slave (
        input  stall, flush, in_valid,
        input  rs1_data, rs2_data, imm,
        input  rs1_addr, rs2_addr, rd_addr,
        input  alu_op, funct3, funct7_b5,
        input  alu_src, reg_write, mem_read,
        input  mem_write, mem_to_reg, branch,
        output out_rs1_data, out_rs2_data, out_imm,
        output out_rs1_addr, out_rs2_addr, out_rd_addr,
        output out_alu_src, out_reg_write, out_mem_read,
        output out_mem_write, out_mem_to_reg, out_branch,
        output alu_control, out_valid, illegal_op
    );
endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU-control decoder: decoder class + funct fields -> ALU code.
module alu_ctrl_dec
    import pipeline_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output logic [3:0] alu_code
);
    always_comb begin
        alu_code = ALU_ILL;
        unique case (alu_op)
            AOP_MEM: alu_code = ALU_ADD;
            AOP_BR:  alu_code = ALU_SUB;
            AOP_R, AOP_I: begin
                unique case (funct3)
                    3'b000: begin
                        // Only R-type uses funct7 to pick SUB; ADDI has no SUBI.
                        if (alu_op == AOP_R && funct7_b5)
                            alu_code = ALU_SUB;
                        else
                            alu_code = ALU_ADD;
                    end
                    3'b111:  alu_code = ALU_AND;
                    3'b110:  alu_code = ALU_OR;
                    default: alu_code = ALU_ILL;
                endcase
            end
            default: alu_code = ALU_ILL;
        endcase
    end
endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with ALU-control decode, stall hold and bubble insert.
module id_ex_reg
    import pipeline_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    id_ex_reg_if.slave   bus
);
    logic [3:0] alu_code;
    id_ex_t     load_v;
    id_ex_t     state_d;
    id_ex_t     state_q;

    alu_ctrl_dec u_dec (
        .alu_op    (bus.alu_op),
        .funct3    (bus.funct3),
        .funct7_b5 (bus.funct7_b5),
        .alu_code  (alu_code)
    );

    always_comb begin
        load_v                  = '0;
        load_v.ctrl.valid       = 1'b1;
        load_v.ctrl.illegal     = (alu_code == ALU_ILL);
        load_v.ctrl.alu_src     = bus.alu_src;
        load_v.ctrl.reg_write   = bus.reg_write;
        load_v.ctrl.mem_read    = bus.mem_read;
        load_v.ctrl.mem_write   = bus.mem_write;
        load_v.ctrl.mem_to_reg  = bus.mem_to_reg;
        load_v.ctrl.branch      = bus.branch;
        load_v.ctrl.alu_control = alu_code;
        load_v.rs1_data         = bus.rs1_data;
        load_v.rs2_data         = bus.rs2_data;
        load_v.imm              = bus.imm;
        load_v.rs1_addr         = bus.rs1_addr;
        load_v.rs2_addr         = bus.rs2_addr;
        load_v.rd_addr          = bus.rd_addr;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush)
            state_d = bubble();
        else if (bus.stall)
            state_d = state_q;
        else if (!bus.in_valid)
            state_d = bubble();
        else
            state_d = load_v;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= bubble();
        else
            state_q <= state_d;
    end

    assign bus.out_valid      = state_q.ctrl.valid;
    assign bus.illegal_op     = state_q.ctrl.illegal;
    assign bus.out_alu_src    = state_q.ctrl.alu_src;
    assign bus.out_reg_write  = state_q.ctrl.reg_write;
    assign bus.out_mem_read   = state_q.ctrl.mem_read;
    assign bus.out_mem_write  = state_q.ctrl.mem_write;
    assign bus.out_mem_to_reg = state_q.ctrl.mem_to_reg;
    assign bus.out_branch     = state_q.ctrl.branch;
    assign bus.alu_control    = state_q.ctrl.alu_control;
    assign bus.out_rs1_data   = state_q.rs1_data;
    assign bus.out_rs2_data   = state_q.rs2_data;
    assign bus.out_imm        = state_q.imm;
    assign bus.out_rs1_addr   = state_q.rs1_addr;
    assign bus.out_rs2_addr   = state_q.rs2_addr;
    assign bus.out_rd_addr    = state_q.rd_addr;
endmodule
